demux_dispatch_ctrl: RTL and testbench
======================================

# demux_dispatch_ctrl

Round-robin / directed dispatcher that sequences a 1-to-4 demultiplexing datapath. It accepts a single valid/ready input stream, registers each word, and steers it to exactly one of four output lanes. The lane is chosen either by rotating round-robin over enabled lanes or by an explicit select. It sits between a single producer and four lane consumers, replacing bare combinational select with handshaked, one-hot, never-X outputs.

## Interface
- WIDTH, 8, data width of every word
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode  in  1  0 = round-robin over lane_en, 1 = directed by sel
- sel  in  2  target lane in directed mode
- lane_en  in  4  per-lane enable mask for round-robin
- in_valid  in  1  producer word valid
- in_ready  out  1  dispatcher can accept a word
- in_data  in  WIDTH  producer word
- out_valid  out  4  one-hot lane valid; never more than one bit set
- out_ready  in  4  per-lane consumer ready
- out_data  out  WIDTH  shared lane data bus, qualified by out_valid
- busy  out  1  a word is held awaiting transfer

## Operation
- FSM states: IDLE (no held word) and HOLD (word registered, lane latched).
- Capture: on in_valid && in_ready, register in_data into hold_q, latch lane_q, go/stay HOLD.
- in_ready = (state==IDLE || out_ready[lane_q]) && pick_ok. pick_ok = 1 in directed mode; in round-robin mode, pick_ok = |lane_en.
- Lane choice at capture only:
  - mode=1: lane_q = sel.
  - mode=0: first set bit of lane_en at or after rr_ptr, searching upward with wrap 3->0.
- mode, sel and lane_en are sampled only at capture. Changes while in HOLD do not affect the held word.
- HOLD: out_valid = 1 << lane_q, out_data = hold_q. Transfer when out_ready[lane_q]=1. Other lanes' out_ready are ignored.
- On transfer without a new capture, return to IDLE. With a simultaneous capture, stay in HOLD with the new word and lane (back-to-back).
- rr_ptr advances to (lane_q+1) mod 4 on every round-robin transfer. It is unchanged by directed-mode transfers.
- Directed mode to a lane whose lane_en bit is 0 is still dispatched; lane_en gates round-robin only.
- Valid stability: once out_valid is asserted, out_data and lane_q are held until transfer.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=0 during the reset cycle, busy=0, state=IDLE, rr_ptr=0, hold_q=0.
- Latency: word captured at edge N appears on out_valid/out_data in cycle N+1.
- Throughput: 1 word/cycle when the selected lane holds out_ready high.
- A transfer and a capture in the same cycle are both honored; no bubble.
- Reset mid-HOLD drops the held word. out_valid deasserts in the cycle after the reset edge.
- out_data is 0 whenever out_valid=0 (registered clear on return to IDLE). Outputs are never X.

## Configuration
- DEMUX_DISPATCH_STATS_EN defined:
  - Adds input stat_clr (1 bit) and output lane_count (4 x 16 bits).
  - Each counter increments on a transfer to its lane and saturates at 16'hFFFF.
  - stat_clr zeroes all counters synchronously. stat_clr takes priority over a same-cycle increment.
  - rst also zeroes the counters.
- Macro undefined: no counters, stat_clr and lane_count ports absent; dispatch behaviour identical.

## Structure
- Shared package demux_dispatch_pkg holds:
  - typedef lane_t (logic [1:0]) and constant NUM_LANES = 4.
  - typedef state_t enum {IDLE, HOLD}.
  - constant CNT_W = 16.
- One sub-module, demux_rr_pick: combinational rotating priority pick.
  - Inputs: mask[4], ptr[2].
  - Outputs: lane[2], found.
- FSM, hold registers and counters live in the top.

## Test plan
- Reset/idle: assert rst 2 cycles with in_valid=1, in_data=8'hAA -> out_valid=4'b0000, out_data=0, busy=0; no word dispatched after rst drops until a new capture.
- Round-robin, all lanes enabled, out_ready=4'b1111: stream 8'h10..8'h15 back-to-back -> out_valid sequence 0001,0010,0100,1000,0001,0010, one per cycle, data in order.
- Masked round-robin: lane_en=4'b1010, 4 words -> lanes 1,3,1,3; lane_en=0 -> in_ready=0 and nothing accepted.
- Directed backpressure: mode=1, sel=2, out_ready[2]=0 for 3 cycles with word 8'h5C -> out_valid=4'b0100 and out_data=8'h5C held stable, in_ready=0; sel changed to 0 meanwhile has no effect; transfer on the cycle out_ready[2]=1.
- Reset mid-HOLD: word pending on lane 3 with out_ready=0, pulse rst -> out_valid=0 next cycle, rr_ptr=0 (next round-robin word goes to lane 0).
- With DEMUX_DISPATCH_STATS_EN: 5 transfers to lane 1, then stat_clr in the same cycle as a sixth transfer -> lane_count[1] reads 0; preload near saturation -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/demux_dispatch_pkg.sv
// Shared types and constants for the 1-to-4 dispatch controller.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package demux_dispatch_pkg;

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 16;

    typedef logic [1:0] lane_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot lane vector for a lane index.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input lane_t lane);
        return NUM_LANES'(1) << lane;
    endfunction

endpackage

// File: rtl/demux_dispatch_if.sv
// Producer-side stream plus four lane consumers sharing one data bus.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready toward the producer, per-lane out_ready from consumers.
interface demux_dispatch_if #(parameter int WIDTH = 8);
    import demux_dispatch_pkg::*;

    logic                 mode;
    lane_t                sel;
    logic [NUM_LANES-1:0] lane_en;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [NUM_LANES-1:0] out_valid;
    logic [NUM_LANES-1:0] out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 busy;

    // Environment side: producer, lane consumers and configuration.
    modport master (
        output mode, sel, lane_en, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Dispatcher side.
    modport slave (
        input  mode, sel, lane_en, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/demux_rr_pick.sv
// Rotating priority pick: first set mask bit at or after ptr, wrapping 3->0.
// Latency: combinational.
// Backpressure: none; found=0 when the mask is empty.
module demux_rr_pick
    import demux_dispatch_pkg::*;
(
    input  logic [NUM_LANES-1:0] mask,
    input  lane_t                ptr,
    output lane_t                lane,
    output logic                 found
);

    lane_t idx;

    // Scan from farthest to nearest so the nearest set bit is written last and wins.
    always_comb begin
        lane  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            idx = lane_t'(ptr + lane_t'(i));
            if (mask[idx]) begin
                lane  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Handshaked 1-to-4 dispatcher, round-robin or directed; DEMUX_DISPATCH_STATS_EN adds per-lane counters.
// Latency: word captured at edge N is presented one-hot on its lane in cycle N+1.
// Backpressure: in_ready drops while the held word's lane is not ready; same-cycle transfer+capture has no bubble.
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef DEMUX_DISPATCH_STATS_EN
    input  logic                            stat_clr,
    output logic [NUM_LANES-1:0][CNT_W-1:0] lane_count,
`endif
    demux_dispatch_if.slave                 bus
);

    state_t               state_q;
    lane_t                lane_q;
    lane_t                rr_ptr_q;
    logic                 rr_q;        // held word was chosen round-robin
    logic [WIDTH-1:0]     hold_q;
    logic [NUM_LANES-1:0] out_valid_q;

    lane_t rr_lane;
    lane_t ptr_eff;
    lane_t cap_lane;
    logic  rr_found;
    logic  pick_ok;
    logic  xfer;
    logic  cap;

    assign xfer = (state_q == HOLD) && bus.out_ready[lane_q];

    // A round-robin word leaving this cycle moves the pointer now, so a
    // back-to-back capture already rotates past the lane just served.
    assign ptr_eff = (xfer && rr_q) ? lane_t'(lane_q + 2'd1) : rr_ptr_q;

    demux_rr_pick u_pick (
        .mask  (bus.lane_en),
        .ptr   (ptr_eff),
        .lane  (rr_lane),
        .found (rr_found)
    );

    assign pick_ok      = bus.mode ? 1'b1 : rr_found;
    assign cap_lane     = bus.mode ? bus.sel : rr_lane;
    assign bus.in_ready = !rst && ((state_q == IDLE) || xfer) && pick_ok;
    assign cap          = bus.in_valid && bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = hold_q;
    assign bus.busy      = (state_q == HOLD);

    // Dispatch FSM: capture latches word, lane and mode; transfer without capture clears to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            rr_ptr_q    <= '0;
            rr_q        <= 1'b0;
            hold_q      <= '0;
            out_valid_q <= '0;
        end else begin
            rr_ptr_q <= ptr_eff;
            if (cap) begin
                state_q     <= HOLD;
                lane_q      <= cap_lane;
                rr_q        <= !bus.mode;
                hold_q      <= bus.in_data;
                out_valid_q <= lane_onehot(cap_lane);
            end else if (xfer) begin
                state_q     <= IDLE;
                rr_q        <= 1'b0;
                hold_q      <= '0;
                out_valid_q <= '0;
            end
        end
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q;

    // Per-lane transfer counters: clear beats increment, saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            cnt_q <= '0;
        end else if (xfer && (cnt_q[lane_q] != '1)) begin
            cnt_q[lane_q] <= cnt_q[lane_q] + CNT_W'(1);
        end
    end

    assign lane_count = cnt_q;
`endif

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl with hand-computed expectations.
// Latency: inputs change 1 time unit after a rising edge, outputs checked there too.
// Backpressure: exercised via out_ready patterns per lane.
module tb_demux_dispatch_ctrl;
    import demux_dispatch_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    demux_dispatch_if #(.WIDTH(8)) bus ();

`ifdef DEMUX_DISPATCH_STATS_EN
    logic                            stat_clr;
    logic [NUM_LANES-1:0][CNT_W-1:0] lane_count;
`endif

    demux_dispatch_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef DEMUX_DISPATCH_STATS_EN
        .stat_clr   (stat_clr),
        .lane_count (lane_count),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_lanes [4];
        n_checks = 0;
        n_fail   = 0;

        // Reset with a valid word on the input: nothing must be taken.
        rst           = 1'b1;
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.lane_en   = 4'b1111;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAA;
`ifdef DEMUX_DISPATCH_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_out_valid", 32'(bus.out_valid), 32'h0);
            check("rst_out_data",  32'(bus.out_data),  32'h0);
            check("rst_busy",      32'(bus.busy),      32'h0);
            check("rst_in_ready",  32'(bus.in_ready),  32'h0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check("idle_out_valid", 32'(bus.out_valid), 32'h0);
        check("idle_busy",      32'(bus.busy),      32'h0);

        // Round-robin over all lanes at full rate.
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + k);
            #1;
            check("rr_in_ready", 32'(bus.in_ready), 32'h1);
            step();
            check("rr_out_valid", 32'(bus.out_valid), 32'(4'b0001 << (k % 4)));
            check("rr_out_data",  32'(bus.out_data),  32'(8'h10 + k));
        end
        bus.in_valid = 1'b0;
        step();
        check("rr_drain_valid", 32'(bus.out_valid), 32'h0);
        check("rr_drain_data",  32'(bus.out_data),  32'h0);

        // Masked round-robin from a fresh pointer.
        rst = 1'b1;
        step();
        rst         = 1'b0;
        bus.lane_en = 4'b1010;
        exp_lanes[0] = 4'b0010;
        exp_lanes[1] = 4'b1000;
        exp_lanes[2] = 4'b0010;
        exp_lanes[3] = 4'b1000;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h20 + k);
            step();
            check("mask_out_valid", 32'(bus.out_valid), 32'(exp_lanes[k]));
            check("mask_out_data",  32'(bus.out_data),  32'(8'h20 + k));
        end
        bus.in_valid = 1'b0;
        step();
        bus.lane_en  = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        #1;
        check("empty_mask_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        check("empty_mask_out_valid", 32'(bus.out_valid), 32'h0);
        check("empty_mask_busy",      32'(bus.busy),      32'h0);

        // Directed to lane 2 (disabled in lane_en) under backpressure.
        bus.mode      = 1'b1;
        bus.sel       = 2'd2;
        bus.out_ready = 4'b1011;
        bus.in_data   = 8'h5C;
        step();
        check("dir_out_valid", 32'(bus.out_valid), 32'h4);
        check("dir_out_data",  32'(bus.out_data),  32'h5C);
        bus.sel     = 2'd0;
        bus.in_data = 8'h77;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("dir_stall_in_ready", 32'(bus.in_ready), 32'h0);
            step();
            check("dir_stall_valid", 32'(bus.out_valid), 32'h4);
            check("dir_stall_data",  32'(bus.out_data),  32'h5C);
        end
        bus.out_ready = 4'b1111;
        #1;
        check("dir_release_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        check("dir_b2b_valid", 32'(bus.out_valid), 32'h1);
        check("dir_b2b_data",  32'(bus.out_data),  32'h77);
        bus.in_valid = 1'b0;
        step();
        check("dir_drain_valid", 32'(bus.out_valid), 32'h0);

        // Move rr_ptr off zero, then strand a word on lane 3 and reset.
        bus.mode     = 1'b0;
        bus.lane_en  = 4'b1111;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3A;
        step();
        check("pre_rst_rr_valid", 32'(bus.out_valid), 32'h1);
        bus.mode      = 1'b1;
        bus.sel       = 2'd3;
        bus.in_data   = 8'h3C;
        bus.out_ready = 4'b0111;
        step();
        check("pre_rst_hold_valid", 32'(bus.out_valid), 32'h8);
        check("pre_rst_hold_data",  32'(bus.out_data),  32'h3C);
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        step();
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_out_data",  32'(bus.out_data),  32'h0);
        check("mid_rst_busy",      32'(bus.busy),      32'h0);
        rst           = 1'b0;
        bus.mode      = 1'b0;
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h40;
        step();
        check("post_rst_rr_lane0", 32'(bus.out_valid), 32'h1);
        check("post_rst_rr_data",  32'(bus.out_data),  32'h40);
        bus.in_valid = 1'b0;
        step();
        check("post_rst_drain", 32'(bus.out_valid), 32'h0);

`ifdef DEMUX_DISPATCH_STATS_EN
        // Counters: five transfers on lane 1, clear beats the sixth.
        rst = 1'b1;
        step();
        rst          = 1'b0;
        bus.mode     = 1'b1;
        bus.sel      = 2'd1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_data = 8'(k);
            step();
        end
        check("cnt_lane1_five", 32'(lane_count[1]), 32'd5);
        bus.in_valid = 1'b0;
        stat_clr     = 1'b1;
        step();
        stat_clr = 1'b0;
        check("cnt_lane1_clr", 32'(lane_count[1]), 32'd0);
        // Saturation on lane 2.
        bus.sel      = 2'd2;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check("cnt_lane2_sat", 32'(lane_count[2]), 32'h0000FFFF);
        check("cnt_lane1_idle", 32'(lane_count[1]), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
